// File: rtl/binary_mul_pkg.sv
// Shared types and constants for the 5x5 pipelined multiplier and its
// operand-issue controller.
package binary_mul_pkg;

    localparam int MUL_W   = 5;
    localparam int MUL_LAT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [MUL_W-1:0]   operand_t;
    typedef logic [2*MUL_W-1:0] product_t;

endpackage

// File: rtl/binary_mul_5_issue_ctrl.sv
// Operand-issue / result-collection controller for the 5x5 pipelined array
// multiplier. Holds mul_a/mul_b frozen for the whole LAT-cycle fill, then
// captures the settled product into a one-entry valid/ready output buffer.
// Optional self-check against a behavioural product: `define BINARY_MUL_CHECK_EN
module binary_mul_5_issue_ctrl
    import binary_mul_pkg::*;
#(
    parameter int W   = MUL_W,
    parameter int LAT = MUL_LAT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    output logic           mul_en,
    input  logic [2*W-1:0] mul_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic           busy
`ifdef BINARY_MUL_CHECK_EN
    ,
    output logic           chk_err,
    output logic [15:0]    chk_cnt
`endif
);

    localparam int CNT_W = $clog2(LAT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     mul_a_q, mul_a_d;
    logic [W-1:0]     mul_b_q, mul_b_d;
    logic             mul_en_q, mul_en_d;
    logic             out_valid_q, out_valid_d;
    logic [2*W-1:0]   out_p_q, out_p_d;
    logic             fill_done;

    assign fill_done = (state_q == RUN) && (cnt_q == CNT_W'(LAT));

    // Next-state, operand load and output-buffer control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_en_d    = mul_en_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        in_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mul_a_d  = in_a;
                    mul_b_d  = in_b;
                    cnt_d    = '0;
                    mul_en_d = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (fill_done) begin
                    out_p_d     = mul_p;
                    out_valid_d = 1'b1;
                    mul_en_d    = 1'b0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Draining the result frees the operand slot on the same edge,
                // so a waiting pair is accepted with no bubble cycle.
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        mul_a_d  = in_a;
                        mul_b_d  = in_b;
                        cnt_d    = '0;
                        mul_en_d = 1'b1;
                        state_d  = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_en_q    <= mul_en_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_en    = mul_en_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign busy      = (state_q != IDLE);

`ifdef BINARY_MUL_CHECK_EN
    logic           chk_err_q, chk_err_d;
    logic [15:0]    chk_cnt_q, chk_cnt_d;
    logic [2*W-1:0] ref_p;

    assign ref_p = (2*W)'(mul_a_q) * (2*W)'(mul_b_q);

    // Sticky mismatch flag and saturating compare count, sampled at capture.
    always_comb begin
        chk_err_d = chk_err_q;
        chk_cnt_d = chk_cnt_q;
        if (fill_done) begin
            if (mul_p != ref_p) begin
                chk_err_d = 1'b1;
            end
            if (chk_cnt_q != 16'hFFFF) begin
                chk_cnt_d = chk_cnt_q + 16'd1;
            end
        end
    end

    // Checker registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q <= 1'b0;
            chk_cnt_q <= '0;
        end else begin
            chk_err_q <= chk_err_d;
            chk_cnt_q <= chk_cnt_d;
        end
    end

    assign chk_err = chk_err_q;
    assign chk_cnt = chk_cnt_q;
`endif

endmodule
